// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle sequencing FSM for the 8-bit pipeline. It sits between the
// instruction register and the fetch/stack/flags datapath and owns the
// two-byte fetch, the LOOP decision, vectored prioritised interrupt entry,
// RTI exit and the hazard-stall hold. Per-opcode ALU and register-file decode
// is done elsewhere.
//
// Parameters
//   DATA_W    instruction / address / vector width (opcode in [7:4], ra [3:2])
//   INT_N     number of interrupt request lines, index 0 = highest priority
//   VEC_BASE  memory address of line 0's vector; line k uses VEC_BASE+k
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-low
//   instruction    in   current IR
//   stall          in   hazard-unit hold request
//   irq            in   interrupt requests, rising-edge sensitive
//   loop_zero      in   ALU reports R[ra]-1 == 0
//   ir_write, imm_write, pc_write                      out
//   pc_src         out  0: PC+1, 2: branch (Rb), 3: stack, 5: memory vector
//   mem_read, mem_write                                out
//   mem_src        out  0: PC, 2: SP, 3: vector address
//   stack_push, stack_pop, save_flags, restore_flags, flush   out
//   vec_addr       out  VEC_BASE + active interrupt index
//   int_ack        out  one-hot, single-cycle acknowledge
//   in_isr         out  interrupt service in progress
//   state          out  encoded FSM state (debug)
//
// Configuration macro
//   CU_NESTED_INT_EN  when defined, a strictly higher-priority line may
//                     preempt a running handler (two levels deep). When
//                     undefined, every line is masked while in_isr=1.
//
// All outputs are combinational from the registered state and the inputs.
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int DATA_W   = 8,
    parameter int INT_N    = 2,
    parameter int VEC_BASE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instruction,
    input  logic              stall,
    input  logic [INT_N-1:0]  irq,
    input  logic              loop_zero,
    output logic              ir_write,
    output logic              imm_write,
    output logic              pc_write,
    output logic [2:0]        pc_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_src,
    output logic              stack_push,
    output logic              stack_pop,
    output logic              save_flags,
    output logic              restore_flags,
    output logic              flush,
    output logic [DATA_W-1:0] vec_addr,
    output logic [INT_N-1:0]  int_ack,
    output logic              in_isr,
    output logic [2:0]        state
);

    localparam int IDX_W = (INT_N > 1) ? $clog2(INT_N) : 1;

    localparam logic [3:0] OP_LOOP = 4'd10;
    localparam logic [3:0] OP_RTI  = 4'd11;
    localparam logic [3:0] OP_LDM  = 4'd12;
    localparam logic [3:0] OP_LDI  = 4'd13;
    localparam logic [3:0] OP_STI  = 4'd14;
    localparam logic [1:0] RA_RTI  = 2'd3;

    localparam logic [2:0] PCS_INC    = 3'd0;
    localparam logic [2:0] PCS_BRANCH = 3'd2;
    localparam logic [2:0] PCS_STACK  = 3'd3;
    localparam logic [2:0] PCS_VECTOR = 3'd5;

    localparam logic [1:0] MS_PC  = 2'd0;
    localparam logic [1:0] MS_SP  = 2'd2;
    localparam logic [1:0] MS_VEC = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH2      = 3'd1,
        S_LOOP_DECIDE = 3'd2,
        S_INT_PUSH    = 3'd3,
        S_INT_VEC     = 3'd4,
        S_RTI_POP     = 3'd5,
        S_RTI_RESTORE = 3'd6
    } state_t;

    state_t           r_state;
    logic [INT_N-1:0] r_irq_d;
    logic [INT_N-1:0] r_pend;
    logic [IDX_W-1:0] r_act_idx;

`ifdef CU_NESTED_INT_EN
    logic [1:0]       r_depth;
    logic [IDX_W-1:0] r_idx_stk [2];
`else
    logic             r_in_isr;
`endif

    logic [3:0]       w_opcode;
    logic [1:0]       w_ra;
    logic             w_two_byte;
    logic             w_is_loop;
    logic             w_is_rti;
    logic [INT_N-1:0] w_mask;
    logic [INT_N-1:0] w_req;
    logic             w_win_valid;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_unused_bits;

    assign w_opcode      = instruction[7:4];
    assign w_ra          = instruction[3:2];
    assign w_two_byte    = (w_opcode == OP_LDM) || (w_opcode == OP_LDI) ||
                           (w_opcode == OP_STI);
    assign w_is_loop     = (w_opcode == OP_LOOP);
    assign w_is_rti      = (w_opcode == OP_RTI) && (w_ra == RA_RTI);
    // The remaining IR bits belong to the decoder, not to sequencing.
    assign w_unused_bits = ^instruction;

    assign state    = r_state;
    assign vec_addr = DATA_W'(VEC_BASE) + DATA_W'(r_act_idx);

`ifdef CU_NESTED_INT_EN
    assign in_isr = (r_depth != 2'd0);
`else
    assign in_isr = r_in_isr;
`endif

    // Interrupt mask: which pending lines are currently not eligible.
    always_comb begin
        w_mask = '0;
`ifdef CU_NESTED_INT_EN
        if (r_depth == 2'd2) begin
            w_mask = '1;
        end else if (r_depth == 2'd1) begin
            // Only strictly higher-priority (lower index) lines may preempt.
            for (int k = 0; k < INT_N; k++) begin
                w_mask[k] = (IDX_W'(k) >= r_act_idx);
            end
        end else begin
            w_mask = '0;
        end
`else
        if (r_in_isr) begin
            w_mask = '1;
        end else begin
            w_mask = '0;
        end
`endif
    end

    assign w_req       = r_pend & ~w_mask;
    assign w_win_valid = |w_req;

    // Priority encoder: scanning downwards leaves the lowest set index.
    always_comb begin
        w_win_idx = '0;
        for (int k = INT_N - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_win_idx = IDX_W'(k);
            end else begin
                w_win_idx = w_win_idx;
            end
        end
    end

    // Control outputs decoded from the current state and inputs.
    always_comb begin
        ir_write      = 1'b0;
        imm_write     = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PCS_INC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_src       = MS_PC;
        stack_push    = 1'b0;
        stack_pop     = 1'b0;
        save_flags    = 1'b0;
        restore_flags = 1'b0;
        flush         = 1'b0;
        int_ack       = '0;
        case (r_state)
            S_IDLE: begin
                ir_write = 1'b1;
                mem_read = 1'b1;
                pc_write = 1'b1;
                if (stall) begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end else if (w_win_valid) begin
                    // Drop the fetched IR; it re-executes after RTI.
                    flush    = 1'b1;
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end else if (w_is_loop || w_is_rti) begin
                    pc_write = 1'b0;
                end else begin
                    pc_write = 1'b1;
                end
            end
            S_FETCH2: begin
                mem_read = 1'b1;
                mem_src  = MS_PC;
                pc_src   = PCS_INC;
                if (stall) begin
                    imm_write = 1'b0;
                    pc_write  = 1'b0;
                end else begin
                    imm_write = 1'b1;
                    pc_write  = 1'b1;
                end
            end
            S_LOOP_DECIDE: begin
                pc_write = 1'b1;
                if (loop_zero) begin
                    pc_src = PCS_INC;
                end else begin
                    pc_src = PCS_BRANCH;
                    flush  = 1'b1;
                end
            end
            S_INT_PUSH: begin
                stack_push = 1'b1;
                mem_write  = 1'b1;
                mem_src    = MS_SP;
                save_flags = 1'b1;
                flush      = 1'b1;
                int_ack    = INT_N'(1'b1) << w_win_idx;
            end
            S_INT_VEC: begin
                mem_read = 1'b1;
                mem_src  = MS_VEC;
                pc_write = 1'b1;
                pc_src   = PCS_VECTOR;
                flush    = 1'b1;
            end
            S_RTI_POP: begin
                stack_pop = 1'b1;
                mem_read  = 1'b1;
                mem_src   = MS_SP;
                pc_write  = 1'b1;
                pc_src    = PCS_STACK;
            end
            S_RTI_RESTORE: begin
                restore_flags = 1'b1;
                flush         = 1'b1;
            end
            default: begin
                ir_write = 1'b0;
            end
        endcase
    end

    // Edge detector and pending latch; a new edge beats a same-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_d <= '0;
            r_pend  <= '0;
        end else begin
            r_irq_d <= irq;
            r_pend  <= (r_pend & ~int_ack) | (irq & ~r_irq_d);
        end
    end

    // Sequencer state, active interrupt index and ISR nesting bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_act_idx <= '0;
`ifdef CU_NESTED_INT_EN
            r_depth      <= 2'd0;
            r_idx_stk[0] <= '0;
            r_idx_stk[1] <= '0;
`else
            r_in_isr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (stall) begin
                        r_state <= S_IDLE;
                    end else if (w_win_valid) begin
                        r_state <= S_INT_PUSH;
                    end else if (w_two_byte) begin
                        r_state <= S_FETCH2;
                    end else if (w_is_loop) begin
                        r_state <= S_LOOP_DECIDE;
                    end else if (w_is_rti) begin
                        r_state <= S_RTI_POP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH2: begin
                    if (stall) begin
                        r_state <= S_FETCH2;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOOP_DECIDE: begin
                    r_state <= S_IDLE;
                end
                S_INT_PUSH: begin
                    r_act_idx <= w_win_idx;
`ifdef CU_NESTED_INT_EN
                    // Depth 0 saves into slot 0, depth 1 into slot 1.
                    r_idx_stk[r_depth[0]] <= r_act_idx;
                    r_depth               <= r_depth + 2'd1;
`else
                    r_in_isr  <= 1'b1;
`endif
                    r_state   <= S_INT_VEC;
                end
                S_INT_VEC: begin
                    r_state <= S_IDLE;
                end
                S_RTI_POP: begin
                    r_state <= S_RTI_RESTORE;
                end
                S_RTI_RESTORE: begin
`ifdef CU_NESTED_INT_EN
                    // Depth 1 restores slot 0, depth 2 restores slot 1.
                    if (r_depth != 2'd0) begin
                        r_act_idx <= r_idx_stk[r_depth[1]];
                        r_depth   <= r_depth - 2'd1;
                    end else begin
                        r_depth   <= 2'd0;
                    end
`else
                    r_in_isr <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
